pipe_rc_adder: RTL
==================

PIPE_RC_ADDER -- requirements
Module: pipe_rc_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, giving the number of carry-chain segments and the pipeline depth.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand set present.
REQ-007 in_ready  output  1  operand set accepted this cycle when in_valid=1.
REQ-008 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in, used only in add mode.
REQ-011 sub  input  1  mode: 0 gives a+b+cin, 1 gives a-b.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result this cycle.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  carry-out of the MSB.
REQ-016 ovf  output  1  signed overflow flag.

Function
REQ-017 WIDTH SHALL be an integer multiple of STAGES, with STAGES in 1..WIDTH; SEG = WIDTH/STAGES.
REQ-018 Per bit, generate SHALL be g=a&b' and propagate SHALL be p=a^b', where b'=b when sub=0 and b'=~b when sub=1.
REQ-019 Carry-in to bit 0 SHALL be cin when sub=0 and forced to 1 when sub=1; cin SHALL be ignored when sub=1.
REQ-020 Each stage k (0..STAGES-1) SHALL ripple-carry only segment k, bits k*SEG..k*SEG+SEG-1, using the registered carry from stage k-1 (stage 0 uses the REQ-019 carry-in).
REQ-021 Operand bits of segments above k SHALL be delay-registered alongside stage k, and completed sum bits of lower segments SHALL be carried forward, so all WIDTH sum bits emerge aligned.
REQ-022 Each stage register SHALL hold: valid bit, segment carry, partial sum, remaining g/p (or operands), and the sign information needed for ovf.
REQ-023 Latency SHALL be exactly STAGES cycles: an operand set accepted at edge N appears with out_valid=1 after edge N+STAGES, provided there is no stall.
REQ-024 Throughput SHALL be one operation per cycle when out_ready=1.
REQ-025 Stall SHALL be global: advance = out_ready | ~out_valid; in_ready = advance.
REQ-026 When advance=0, every pipeline register SHALL hold, and sum, cout, ovf and out_valid SHALL remain stable.
REQ-027 Bubbles SHALL advance like data when advance=1, with a valid bit of 0; bubbles need not collapse.
REQ-028 An input SHALL be accepted only when in_valid & in_ready; otherwise a bubble SHALL enter stage 0.
REQ-029 cout SHALL be the raw carry out of bit WIDTH-1; in sub mode cout=1 means no borrow (a>=b unsigned).
REQ-030 ovf SHALL equal the carry into the MSB XOR the carry out of the MSB.
REQ-031 sum SHALL equal (a + b' + c0) mod 2^WIDTH.
REQ-032 Results SHALL leave in acceptance order; no operation SHALL be lost or duplicated under any out_ready pattern.
REQ-033 When STAGES=1, the block SHALL be a full-width ripple add into one output register with latency 1.
REQ-034 sum, cout and ovf SHALL be don't-care when out_valid=0, but SHALL be registered outputs, with no combinational path from a, b or cin.

Reset
REQ-035 When rst=1 at a rising edge, all stage valid bits SHALL clear, and out_valid SHALL be 0 after that edge.
REQ-036 Reset SHALL clear sum, cout and ovf to 0.
REQ-037 Reset mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear afterwards.
REQ-038 in_ready SHALL be 1 in the first cycle after rst is released.
REQ-039 Inputs presented while rst=1 SHALL NOT be accepted.

Verification (WIDTH=16, STAGES=4 unless stated)
REQ-040 Full carry propagation: a=0xFFFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 4 cycles later out_valid=1, sum=0x0000, cout=1, ovf=0.
REQ-041 Subtract overflow: a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1; a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-042 Streaming: 3 back-to-back ops (1+2, 0x7FFF+1, 0x00FF+0x0F01 with cin=1) -> out_valid on 3 consecutive cycles giving 0x0003 (ovf=0), 0x8000 (ovf=1), 0x1001 (ovf=0), in order.
REQ-043 Backpressure: pipe full, out_ready=0 for 3 cycles -> in_ready=0, outputs frozen; after out_ready=1, all 4 results drain in order with none lost.
REQ-044 Reset mid-flight: 2 ops in flight, rst=1 for 1 cycle -> out_valid=0 for 4 cycles afterwards with no new input, and in_ready=1 after release.
REQ-045 Configuration STAGES=1 and STAGES=16: 10,000 random ops with random out_ready -> output stream matches a reference model, with latency 1 and 16 respectively.

Source files
------------

// File: rtl/pipe_rc_adder.sv
// rtl/pipe_rc_adder.sv - segmented ripple-carry adder/subtractor, one carry segment per pipeline stage
module pipe_rc_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  s_q  [STAGES];
    logic [WIDTH-1:0]  a_q  [STAGES];
    logic [WIDTH-1:0]  bx_q [STAGES];
    logic              ovf_q;

    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  bx_in [STAGES];

    logic [STAGES-1:0] c_d;
    logic [WIDTH-1:0]  s_d [STAGES];
    logic              msb_cin;
    logic              advance;

    // Global stall: the whole pipe moves only when the output slot can be vacated.
    assign advance  = out_ready | ~v_q[STAGES-1];
    assign in_ready = advance;

    // Stage 0 takes the raw operands (b inverted and carry forced for subtract);
    // later stages take the previous stage's register.
    always_comb begin
        v_in[0]  = in_valid;
        c_in[0]  = sub | cin;
        s_in[0]  = '0;
        a_in[0]  = a;
        bx_in[0] = sub ? ~b : b;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k]  = v_q[k-1];
            c_in[k]  = c_q[k-1];
            s_in[k]  = s_q[k-1];
            a_in[k]  = a_q[k-1];
            bx_in[k] = bx_q[k-1];
        end
    end

    always_comb begin
        logic carry;
        logic g;
        logic p;
        msb_cin = 1'b0;
        carry   = 1'b0;
        g       = 1'b0;
        p       = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            carry  = c_in[k];
            s_d[k] = s_in[k];
            for (int i = 0; i < SEG; i++) begin
                g = a_in[k][k*SEG+i] & bx_in[k][k*SEG+i];
                p = a_in[k][k*SEG+i] ^ bx_in[k][k*SEG+i];
                // Carry into the MSB is only ever seen in the last segment.
                if (k*SEG+i == WIDTH-1) msb_cin = carry;
                s_d[k][k*SEG+i] = p ^ carry;
                carry = g | (p & carry);
            end
            c_d[k] = carry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                s_q[k]  <= '0;
                a_q[k]  <= '0;
                bx_q[k] <= '0;
            end
        end else if (advance) begin
            v_q   <= v_in;
            c_q   <= c_d;
            ovf_q <= msb_cin ^ c_d[STAGES-1];
            for (int k = 0; k < STAGES; k++) begin
                s_q[k]  <= s_d[k];
                a_q[k]  <= a_in[k];
                bx_q[k] <= bx_in[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
endmodule
